serial_frame_tx: RTL



---
 rtl/serial_frame_pkg.sv | 31 +++
 rtl/serial_frame_tx_shreg.sv | 40 ++++
 rtl/serial_frame_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and its future receiver.
// State encodings, default word width and a constant-evaluable clog2.
package serial_frame_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    stIdle   = IDLE,
    stStart  = START,
    stData   = DATA,
    stParity = PARITY,
    stStop   = STOP
  } txState_t;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_frame_tx_shreg.sv
// Parallel-load right-shift register with data-bit counter for serial_frame_tx.
// lsb is the next bit to go on the line; lastBit flags the final data cycle.
module serial_frame_tx_shreg
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic              count,
  input  logic [DATA_W-1:0] loadData,
  output logic              lsb,
  output logic              lastBit
);

  localparam int unsigned CNT_W = clog2(DATA_W) + 1;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bitCount;

  // Load restarts the count; shift and count are independent enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bitCount <= '0;
    end else if (load) begin
      shreg    <= loadData;
      bitCount <= '0;
    end else begin
      if (shift) shreg <= shreg >> 1;
      if (count) bitCount <= bitCount + CNT_W'(1);
    end
  end

  assign lsb     = shreg[0];
  assign lastBit = (bitCount == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/serial_frame_tx.sv
// Framed bit-serial transmitter: start bit, DATA_W bits LSB-first, optional
// even parity (define SERIAL_TX_PARITY_EN), stop bit. Outputs are registered.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inputData,
  input  logic              inputValid,
  output logic              outputReady,
  output logic              outputSerial,
  output logic              outputStrobe,
  output logic              outputBusy,
  output logic              outputFrameDone
);

  txState_t state, stateNext;

  logic accept;
  logic load, shift, count;
  logic lsb, lastBit;
  logic serialNext, readyNext, strobeNext, busyNext, doneNext;

  assign accept = inputValid && outputReady;

  serial_frame_tx_shreg #(.DATA_W(DATA_W)) uShreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .count    (count),
    .loadData (inputData),
    .lsb      (lsb),
    .lastBit  (lastBit)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic parityBit;

  // Even parity captured with the word so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (reset)     parityBit <= 1'b0;
    else if (load) parityBit <= ^inputData;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= stIdle;
      outputSerial    <= IDLE_LEVEL;
      outputReady     <= 1'b1;
      outputStrobe    <= 1'b0;
      outputBusy      <= 1'b0;
      outputFrameDone <= 1'b0;
    end else begin
      state           <= stateNext;
      outputSerial    <= serialNext;
      outputReady     <= readyNext;
      outputStrobe    <= strobeNext;
      outputBusy      <= busyNext;
      outputFrameDone <= doneNext;
    end
  end

  // Next state plus outputs decoded from the state being entered.
  always_comb begin
    stateNext  = state;
    load       = 1'b0;
    shift      = 1'b0;
    count      = 1'b0;
    serialNext = IDLE_LEVEL;
    readyNext  = 1'b0;
    strobeNext = 1'b0;
    busyNext   = 1'b0;
    doneNext   = 1'b0;

    case (state)
      stIdle: begin
        if (accept) begin
          stateNext = stStart;
          load      = 1'b1;
        end
      end
      stStart: begin
        stateNext = stData;
        shift     = 1'b1;
      end
      stData: begin
        shift = 1'b1;
        count = 1'b1;
        if (lastBit) begin
`ifdef SERIAL_TX_PARITY_EN
          stateNext = stParity;
`else
          stateNext = stStop;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      stParity: stateNext = stStop;
`endif
      stStop: begin
        if (accept) begin
          stateNext = stStart;
          load      = 1'b1;
        end else begin
          stateNext = stIdle;
        end
      end
      default: stateNext = stIdle;
    endcase

    // lsb already holds the bit for the data cycle being entered.
    case (stateNext)
      stIdle: readyNext = 1'b1;
      stStart: begin
        serialNext = ~IDLE_LEVEL;
        busyNext   = 1'b1;
      end
      stData: begin
        serialNext = lsb;
        strobeNext = 1'b1;
        busyNext   = 1'b1;
      end
`ifdef SERIAL_TX_PARITY_EN
      stParity: begin
        serialNext = parityBit;
        busyNext   = 1'b1;
      end
`endif
      stStop: begin
        readyNext = 1'b1;
        busyNext  = 1'b1;
        doneNext  = 1'b1;
      end
      default: readyNext = 1'b1;
    endcase
  end

endmodule
